// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared opcodes, state encoding and select encodings for multicycle control
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIEX, S_ADDIWB
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic addi;
  } iclass_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// rtl/mc_opcode_decode.sv - opcode to one-hot instruction class plus illegal flag
module mc_opcode_decode
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output iclass_t        cls,
  output logic           illegal
);

  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    case (opcode)
      OPW'(OP_RTYPE): cls.rtype = 1'b1;
      OPW'(OP_LW):    cls.lw    = 1'b1;
      OPW'(OP_SW):    cls.sw    = 1'b1;
      OPW'(OP_BEQ):   cls.beq   = 1'b1;
      OPW'(OP_J):     cls.j     = 1'b1;
      OPW'(OP_ADDI):  cls.addi  = 1'b1;
      default:        illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle datapath
module multicycle_control
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           i_or_d,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           illegal_op
);

  state_t  state, next;
  iclass_t cls;
  logic    dec_illegal;
  logic    is_lw_q;
  ctrl_t   ctrl, ctrl_o;

  mc_opcode_decode #(.OPW(OPW)) u_decode (
    .opcode  (opcode),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  // lw/sw share MEMADR, so the load/store choice is remembered from DECODE
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      is_lw_q <= 1'b0;
    end else begin
      state <= next;
      if (state == S_DECODE) is_lw_q <= cls.lw;
    end
  end

  always_comb begin
    ctrl = '0;
    next = state;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) next = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        if (cls.lw || cls.sw) next = S_MEMADR;
        else if (cls.rtype)   next = S_EXEC;
        else if (cls.beq)     next = S_BRANCH;
        else if (cls.j)       next = S_JUMP;
        else if (cls.addi)    next = S_ADDIEX;
        else begin
          ctrl.illegal_op = dec_illegal;
          next            = S_FETCH;
        end
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        next           = is_lw_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready) next = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        next            = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (mem_ready) next = S_FETCH;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
        next           = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        next           = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        next               = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        next           = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        next           = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        next           = S_FETCH;
      end
      default: next = S_FETCH;
    endcase
  end

  // reset gates every control point so an abandoned instruction cannot write
  assign ctrl_o = reset ? '0 : ctrl;

  assign pc_write      = ctrl_o.pc_write;
  assign pc_write_cond = ctrl_o.pc_write_cond;
  assign i_or_d        = ctrl_o.i_or_d;
  assign mem_read      = ctrl_o.mem_read;
  assign mem_write     = ctrl_o.mem_write;
  assign ir_write      = ctrl_o.ir_write;
  assign mem_to_reg    = ctrl_o.mem_to_reg;
  assign reg_dst       = ctrl_o.reg_dst;
  assign reg_write     = ctrl_o.reg_write;
  assign alu_src_a     = ctrl_o.alu_src_a;
  assign alu_src_b     = ctrl_o.alu_src_b;
  assign alu_op        = ctrl_o.alu_op;
  assign pc_source     = ctrl_o.pc_source;
  assign illegal_op    = ctrl_o.illegal_op;

endmodule
